fifo_rr_read_arbiter: RTL and testbench

Read-side scheduler that shares one downstream stream among CH_NUM async FIFOs. Runs in the FIFOs' read clock domain, watches each FIFO's read-side fill count, grants channels round-robin and drains each grant as a burst of up to BURST_LEN words. Output is a valid/ready stream carrying data, source channel and a burst-end marker. Sits between the async_fifo instances' read ports and the packer/DMA that consumes them.

---
 rtl/fifo_rr_read_arbiter_pkg.sv | 20 ++
 rtl/fifo_rr_read_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_rr_read_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fifo_rr_read_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_read_arbiter_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
// Holds the FSM encoding and the ceil-log2 helper.
package fifo_arb_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // ceil(log2(v)); clogb2(1) = 0
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_read_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester strictly after last in cyclic order.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clogb2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any
);

  logic [W-1:0] idx;

  // N is a power of two, so W-bit wrap gives the cyclic order
  always_comb begin
    idx   = '0;
    grant = last;
    any   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = last + W'(i);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_read_arbiter.sv
// Round-robin burst scheduler over CH_NUM async FIFO read ports.
// Drains each grant into a 2-entry valid/ready output buffer.
module fifo_rr_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WIDTH  = 11,
  parameter int BURST_LEN  = 16,
  parameter int CH_W       = clogb2(CH_NUM)
) (
  input  logic                           sys_clk_i,
  input  logic                           sys_rst_i,
  input  logic [CH_NUM-1:0]              ch_en_i,
  input  logic [CH_NUM*NUM_WIDTH-1:0]    fifo_num_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0]   fifo_dout_i,
  output logic [CH_NUM-1:0]              fifo_rd_en_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  output logic [CH_W-1:0]                m_chan_o,
  output logic                           m_last_o,
  output logic                           busy_o
);

  localparam int BW = clogb2(BURST_LEN) + 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  localparam logic [NUM_WIDTH-1:0] NUM_ONE = NUM_WIDTH'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CH_W-1:0]       chan;
    logic                  last;
  } ent_t;

  state_t state, nxt;

  logic [CH_W-1:0] grant, last_grant, pick;
  logic [BW-1:0]   beat;
  logic            any;

  logic [NUM_WIDTH-1:0]  num_a  [CH_NUM];
  logic [DATA_WIDTH-1:0] dout_a [CH_NUM];
  logic [CH_NUM-1:0]     cand;
  logic [NUM_WIDTH-1:0]  num_g;

  logic            infl_v;
  logic [CH_W-1:0] infl_c;
  logic            infl_l;

  ent_t       b0, b1, w;
  logic [1:0] cnt;
  logic       pop, cap;
  logic [2:0] occ;
  logic       credit_ok;
  logic       issue, tag_last;
  logic [CH_NUM-1:0] rd_en;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_unpack
    assign num_a[k]  = fifo_num_i[k*NUM_WIDTH +: NUM_WIDTH];
    assign dout_a[k] = fifo_dout_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign cand[k]   = ch_en_i[k] & (num_a[k] != '0);
  end

  rr_pick #(
    .N (CH_NUM),
    .W (CH_W)
  ) u_pick (
    .req   (cand),
    .last  (last_grant),
    .grant (pick),
    .any   (any)
  );

  assign num_g = num_a[grant];

  assign pop = m_valid_o & m_ready_i;
  assign cap = infl_v;
  assign occ = {1'b0, cnt} + {2'b0, infl_v} - {2'b0, pop};
  assign credit_ok = (occ <= 3'd1);

  assign w.data = dout_a[infl_c];
  assign w.chan = infl_c;
  assign w.last = infl_l;

  // State register
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) state <= ST_ARB;
    else           state <= nxt;
  end

  // Next state and read issue; a read needs data and buffer credit
  always_comb begin
    nxt      = state;
    issue    = 1'b0;
    tag_last = 1'b0;
    rd_en    = '0;
    unique case (state)
      ST_ARB: begin
        if (any) nxt = ST_BURST;
      end
      ST_BURST: begin
        tag_last = (beat == BEAT_MAX) | (num_g == NUM_ONE);
        if (num_g == '0) begin
          nxt = ST_ARB;
        end else if (credit_ok) begin
          issue        = 1'b1;
          rd_en[grant] = 1'b1;
          if (tag_last) nxt = ST_ARB;
        end
      end
      default: nxt = ST_ARB;
    endcase
  end

  // Grant, round-robin pointer and beat count
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      grant      <= '0;
      last_grant <= CH_W'(CH_NUM - 1);
      beat       <= '0;
    end else if (state == ST_ARB) begin
      if (any) begin
        grant      <= pick;
        last_grant <= pick;
        beat       <= '0;
      end
    end else if (issue) begin
      beat <= beat + 1'b1;
    end
  end

  // One-deep tag slot for the read whose data lands next cycle
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      infl_v <= 1'b0;
      infl_c <= '0;
      infl_l <= 1'b0;
    end else begin
      infl_v <= issue;
      infl_c <= grant;
      infl_l <= tag_last;
    end
  end

  // Two-entry output FIFO; b0 is the head presented downstream
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      cnt <= '0;
      b0  <= '0;
      b1  <= '0;
    end else begin
      unique case ({cap, pop})
        2'b10: begin
          if (cnt == 2'd0) b0 <= w;
          else             b1 <= w;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          b0  <= b1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            b0 <= w;
          end else begin
            b0 <= b1;
            b1 <= w;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = (cnt != 2'd0);
  assign m_data_o     = b0.data;
  assign m_chan_o     = b0.chan;
  assign m_last_o     = b0.last;
  assign busy_o       = (state == ST_BURST) | infl_v | (cnt != 2'd0);

endmodule

// File: tb/tb_fifo_rr_read_arbiter.sv
// Directed bench for fifo_rr_read_arbiter.
// Behavioural FIFO models feed the DUT; a negedge monitor logs beats.
module tb_fifo_rr_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic [43:0] fifo_num;
  logic [31:0] fifo_dout;
  logic [3:0]  rd_en;
  logic        m_valid, m_ready;
  logic [7:0]  m_data;
  logic [1:0]  m_chan;
  logic        m_last, busy;

  always #5 clk = ~clk;

  fifo_rr_read_arbiter dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .ch_en_i      (ch_en),
    .fifo_num_i   (fifo_num),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_en_o (rd_en),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .m_chan_o     (m_chan),
    .m_last_o     (m_last),
    .busy_o       (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: word = {channel, sequence}; count drops per read
  logic [10:0] num  [4];
  logic [7:0]  dout [4];
  logic [5:0]  seq  [4];
  logic        set_stb;
  logic [10:0] set_num [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        num[k]  <= '0;
        dout[k] <= '0;
        seq[k]  <= '0;
      end else begin
        if (rd_en[k]) begin
          dout[k] <= {2'(k), seq[k]};
          seq[k]  <= seq[k] + 6'd1;
        end
        if (set_stb) num[k] <= set_num[k];
        else if (rd_en[k] && num[k] != 0) num[k] <= num[k] - 11'd1;
      end
    end
  end

  always_comb begin
    fifo_num  = '0;
    fifo_dout = '0;
    for (int k = 0; k < 4; k++) begin
      fifo_num[k*11 +: 11] = num[k];
      fifo_dout[k*8 +: 8]  = dout[k];
    end
  end

  // Monitor: logs accepted words and counts protocol violations
  typedef struct {
    logic [7:0] d;
    logic [1:0] c;
    logic       l;
    int         t;
  } beat_t;

  beat_t lg[$];
  int rx [4];
  int data_err = 0, hold_err = 0, out_err = 0, hot_err = 0;
  int rd2_cnt = 0, outstanding = 0;
  logic hold = 1'b0;
  logic [7:0] hd;
  logic [1:0] hc;
  logic hl;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) rx[k] = 0;
      outstanding = 0;
      hold = 1'b0;
    end else begin
      if (hold && (!m_valid || m_data !== hd ||
                   m_chan !== hc || m_last !== hl))
        hold_err++;
      hold = m_valid && !m_ready;
      hd = m_data;
      hc = m_chan;
      hl = m_last;
      if (rd_en[2]) rd2_cnt++;
      if ($countones(rd_en) > 1) hot_err++;
      outstanding += $countones(rd_en);
      if (m_valid && m_ready) outstanding--;
      if (outstanding > 2 || outstanding < 0) out_err++;
      if (m_valid && m_ready) begin
        if (m_data !== {m_chan, 6'(rx[m_chan])}) data_err++;
        rx[m_chan]++;
        lg.push_back('{d: m_data, c: m_chan, l: m_last, t: cyc});
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int b,
                      input int c, input int d);
    set_num[0] = 11'(a);
    set_num[1] = 11'(b);
    set_num[2] = 11'(c);
    set_num[3] = 11'(d);
    set_stb = 1'b1;
    tick(1);
    set_stb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_words(input string tag, input int target,
                            input int bound);
    int n;
    n = 0;
    while (lg.size() < target && n < bound) begin
      tick(1);
      n++;
    end
    check(tag, 32'(lg.size() >= target), 32'd1);
  endtask

  int b, c0, r2, cnt_l, viol;
  logic [3:0] pat;

  initial begin
    rst = 1'b1;
    set_stb = 1'b0;
    m_ready = 1'b1;
    ch_en = 4'hf;
    for (int k = 0; k < 4; k++) set_num[k] = '0;
    tick(3);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_chan", m_chan, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);
    check("idle_busy", busy, 0);

    // ch0 alone, 40 words: bursts 16,16,8
    b = lg.size();
    load(40, 0, 0, 0);
    c0 = cyc;
    wait_words("t1_timeout", b + 40, 120);
    check("t1_latency", lg[b].t - c0, 3);
    check("t1_rate", lg[b+1].t - lg[b].t, 1);
    check("t1_gap", lg[b+16].t - lg[b+15].t, 2);
    check("t1_last_idx",
          {lg[b+15].l, lg[b+31].l, lg[b+39].l}, 3'b111);
    cnt_l = 0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      if (lg[b+i].l) cnt_l++;
      if (lg[b+i].c != 2'd0) viol++;
    end
    check("t1_last_cnt", cnt_l, 3);
    check("t1_chan0", viol, 0);
    tick(5);
    check("t1_idle_busy", busy, 0);
    check("t1_data", data_err, 0);

    // all channels full: grant order 0,1,2,3,0
    do_reset();
    b = lg.size();
    load(100, 100, 100, 100);
    wait_words("t2_timeout", b + 80, 250);
    for (int i = 0; i < 5; i++)
      check($sformatf("t2_grant%0d", i), lg[b+16*i].c, i % 4);
    viol = 0;
    for (int i = 1; i < 80; i++)
      if (lg[b+i].c != lg[b+i-1].c && !lg[b+i-1].l) viol++;
    check("t2_chan_switch", viol, 0);
    check("t2_data", data_err, 0);

    // masked channel 2 is never read until enabled
    do_reset();
    ch_en = 4'b1011;
    b = lg.size();
    r2 = rd2_cnt;
    load(0, 0, 3, 0);
    tick(20);
    check("t3_no_rd2", rd2_cnt - r2, 0);
    check("t3_no_words", lg.size() - b, 0);
    check("t3_busy", busy, 0);
    ch_en = 4'b1111;
    wait_words("t3_timeout", b + 3, 20);
    check("t3_chan", {lg[b].c, lg[b+1].c, lg[b+2].c}, 6'b101010);
    check("t3_last", {lg[b].l, lg[b+1].l, lg[b+2].l}, 3'b001);
    check("t3_data", data_err, 0);

    // backpressure 1,0,0,1 on ch1, 50 words
    do_reset();
    b = lg.size();
    pat = 4'b1001;
    load(0, 50, 0, 0);
    for (int i = 0; i < 400 && lg.size() < b + 50; i++) begin
      m_ready = pat[i % 4];
      tick(1);
    end
    m_ready = 1'b1;
    check("t4_count", lg.size() - b, 50);
    check("t4_credit", out_err, 0);
    check("t4_onehot", hot_err, 0);
    check("t4_hold", hold_err, 0);
    check("t4_data", data_err, 0);
    check("t4_last_idx",
          {lg[b+15].l, lg[b+31].l, lg[b+47].l, lg[b+49].l}, 4'hf);
    cnt_l = 0;
    for (int i = 0; i < 50; i++) if (lg[b+i].l) cnt_l++;
    check("t4_last_cnt", cnt_l, 4);

    // reset mid-burst on ch2; pointer restarts from CH_NUM-1
    do_reset();
    load(0, 0, 30, 0);
    tick(8);
    rst = 1'b1;
    tick(1);
    check("t5_rd_en", rd_en, 0);
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    check("t5_chan", m_chan, 0);
    check("t5_last", m_last, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    tick(1);
    b = lg.size();
    load(0, 5, 0, 5);
    wait_words("t5_timeout", b + 1, 20);
    check("t5_regrant", lg[b].c, 1);
    tick(30);
    check("t5_data_ok", data_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
